// File: rtl/condition_predicate_if.sv
// condition_predicate_if
//   Bundles the branch-condition inputs and the registered predicate result
//   so the evaluator and its driver share one connection.
//   Signals:
//     A_selector, A_negative, A_carryout, A_sentinel, A_external  A-group select + flags
//     B_selector, B_lessthan, B_counter, B_sentinel, B_external   B-group select + flags
//     AB_operator  4-entry truth table applied to {A,B}
//     predicate    registered condition result
//   Modports:
//     master  drives selectors/flags/operator, observes predicate
//     slave   the evaluator: consumes selectors/flags/operator, drives predicate
interface condition_predicate_if #(
  parameter int SELECTOR_WIDTH = 2,
  parameter int OPERATOR_WIDTH = 4
);
  logic [SELECTOR_WIDTH-1:0] A_selector;
  logic                      A_negative;
  logic                      A_carryout;
  logic                      A_sentinel;
  logic                      A_external;
  logic [SELECTOR_WIDTH-1:0] B_selector;
  logic                      B_lessthan;
  logic                      B_counter;
  logic                      B_sentinel;
  logic                      B_external;
  logic [OPERATOR_WIDTH-1:0] AB_operator;
  logic                      predicate;

  modport master (
    output A_selector, A_negative, A_carryout, A_sentinel, A_external,
    output B_selector, B_lessthan, B_counter, B_sentinel, B_external,
    output AB_operator,
    input  predicate
  );

  modport slave (
    input  A_selector, A_negative, A_carryout, A_sentinel, A_external,
    input  B_selector, B_lessthan, B_counter, B_sentinel, B_external,
    input  AB_operator,
    output predicate
  );
endinterface

// File: rtl/condition_predicate.sv
// condition_predicate
//   Two-stage pipelined branch-condition evaluator. Stage 1 registers one
//   flag from group A, one from group B and the operator truth table that
//   goes with them; stage 2 registers predicate = op[{A,B}].
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset, clears every pipeline register
//     bus      condition_predicate_if.slave (selectors, flags, operator in;
//              predicate out)
module condition_predicate #(
  parameter int SELECTOR_WIDTH = 2,
  parameter int OPERATOR_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  condition_predicate_if.slave   bus
);

  if (OPERATOR_WIDTH != 4) begin : g_bad_operator_width
    $error("condition_predicate: OPERATOR_WIDTH must be 4");
  end

  logic [3:0]                a_flags;
  logic [3:0]                b_flags;
  int unsigned               a_idx;
  int unsigned               b_idx;
  logic                      a_sel_flag;
  logic                      b_sel_flag;

  logic                      a_bit;
  logic                      b_bit;
  logic [OPERATOR_WIDTH-1:0] op_d;
  logic                      predicate_q;

  // Flag vectors are ordered by selector code; codes >= 4 (only possible
  // with wider selectors) pick 0.
  always_comb begin
    a_flags    = {bus.A_external, bus.A_sentinel, bus.A_carryout, bus.A_negative};
    b_flags    = {bus.B_external, bus.B_sentinel, bus.B_counter, bus.B_lessthan};
    a_idx      = 32'(bus.A_selector);
    b_idx      = 32'(bus.B_selector);
    a_sel_flag = 1'b0;
    b_sel_flag = 1'b0;
    if (a_idx < 32'd4) a_sel_flag = a_flags[a_idx[1:0]];
    if (b_idx < 32'd4) b_sel_flag = b_flags[b_idx[1:0]];
  end

  // Stage 1: the operator travels with the bits it will be applied to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_bit <= 1'b0;
      b_bit <= 1'b0;
      op_d  <= '0;
    end else begin
      a_bit <= a_sel_flag;
      b_bit <= b_sel_flag;
      op_d  <= bus.AB_operator;
    end
  end

  // Stage 2: truth-table lookup, index = 2*A + B.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      predicate_q <= 1'b0;
    end else begin
      predicate_q <= op_d[{a_bit, b_bit}];
    end
  end

  assign bus.predicate = predicate_q;

endmodule

// File: tb/tb_condition_predicate.sv
// tb_condition_predicate
//   Directed-vector bench for condition_predicate: reset behaviour,
//   always/never, A and B selection, full operator x {A,B} sweep,
//   back-to-back changes and a mid-stream asynchronous reset.
//   Expected results travel through a small scoreboard queue that models
//   the two-edge latency.
module tb_condition_predicate;

  logic clock;
  logic reset_n;

  int checks;
  int errors;

  logic sbq[$];

  condition_predicate_if #(.SELECTOR_WIDTH(2), .OPERATOR_WIDTH(4)) bus ();

  condition_predicate #(
    .SELECTOR_WIDTH(2),
    .OPERATOR_WIDTH(4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // a_flags / b_flags bit k is the flag addressed by selector value k.
  task automatic drive(input logic [1:0] a_sel, input logic [3:0] a_flags,
                       input logic [1:0] b_sel, input logic [3:0] b_flags,
                       input logic [3:0] op);
    bus.A_selector  = a_sel;
    bus.A_negative  = a_flags[0];
    bus.A_carryout  = a_flags[1];
    bus.A_sentinel  = a_flags[2];
    bus.A_external  = a_flags[3];
    bus.B_selector  = b_sel;
    bus.B_lessthan  = b_flags[0];
    bus.B_counter   = b_flags[1];
    bus.B_sentinel  = b_flags[2];
    bus.B_external  = b_flags[3];
    bus.AB_operator = op;
  endtask

  // Drive one vector just after a falling edge, take the rising edge, and
  // check the result that is due now (the vector from one cycle earlier).
  task automatic run(input string tag,
                     input logic [1:0] a_sel, input logic [3:0] a_flags,
                     input logic [1:0] b_sel, input logic [3:0] b_flags,
                     input logic [3:0] op, input logic exp);
    logic due;
    drive(a_sel, a_flags, b_sel, b_flags, op);
    sbq.push_back(exp);
    @(posedge clock);
    @(negedge clock);
    due = sbq.pop_front();
    check(tag, bus.predicate, due);
  endtask

  task automatic random_inputs();
    drive(2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    random_inputs();

    // Reset held: predicate stays 0 across edges regardless of inputs.
    #1 check("reset_initial", bus.predicate, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      random_inputs();
      @(posedge clock);
      #1 check("reset_held", bus.predicate, 1'b0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    sbq.delete();
    sbq.push_back(1'b0);

    // First edge after release shows the cleared stage-1 contents (0),
    // even with an always-true operator; the second edge shows the vector.
    run("post_reset_edge1",   2'd0, 4'b0000, 2'd0, 4'b0000, 4'b1111, 1'b1);
    run("post_reset_edge2",   2'd2, 4'b0000, 2'd3, 4'b0000, 4'b0000, 1'b0);

    // Always / never.
    run("always_flags_a",     2'd0, 4'b1010, 2'd3, 4'b0101, 4'b1111, 1'b1);
    run("never_flags_b",      2'd2, 4'b0101, 2'd1, 4'b1010, 4'b0000, 1'b0);
    run("always_all_ones",    2'd3, 4'b1111, 2'd2, 4'b1111, 4'b1111, 1'b1);
    run("never_all_ones",     2'd1, 4'b1111, 2'd0, 4'b1111, 4'b0000, 1'b0);

    // A select (carryout) with op = A.
    run("a_sel_carry_1",      2'd1, 4'b0010, 2'd0, 4'b0000, 4'b1100, 1'b1);
    run("a_sel_carry_0",      2'd1, 4'b0000, 2'd0, 4'b0000, 4'b1100, 1'b0);
    run("a_sel_carry_only",   2'd1, 4'b1101, 2'd0, 4'b0000, 4'b1100, 1'b0);

    // B select (sentinel) with op = B, then !B.
    run("b_sel_sent_B",       2'd0, 4'b0000, 2'd2, 4'b0100, 4'b1010, 1'b1);
    run("b_sel_sent_notB",    2'd0, 4'b0000, 2'd2, 4'b0100, 4'b0101, 1'b0);

    // Reference operators, a different selector mix every cycle.
    run("op_and_11",          2'd3, 4'b1000, 2'd1, 4'b0010, 4'b1000, 1'b1);
    run("op_and_10",          2'd3, 4'b1000, 2'd0, 4'b0000, 4'b1000, 1'b0);
    run("op_xor_10",          2'd2, 4'b0100, 2'd3, 4'b0000, 4'b0110, 1'b1);
    run("op_eq_11",           2'd0, 4'b0001, 2'd0, 4'b0001, 4'b1001, 1'b1);
    run("op_or_00",           2'd0, 4'b1110, 2'd1, 4'b1101, 4'b1110, 1'b0);
    run("op_notA_00",         2'd2, 4'b1011, 2'd2, 4'b1011, 4'b0011, 1'b1);
    run("op_notB_01",         2'd3, 4'b0111, 2'd3, 4'b1000, 4'b0101, 1'b0);
    run("op_bit1_01",         2'd1, 4'b1101, 2'd2, 4'b0100, 4'b0010, 1'b1);
    run("op_bit2_10",         2'd1, 4'b0010, 2'd1, 4'b1101, 4'b0100, 1'b1);
    run("op_not_bit2_10",     2'd1, 4'b0010, 2'd1, 4'b1101, 4'b1011, 1'b0);

    // Sweep: every operator against every (A,B); selectors and the
    // unselected flags are random so only the addressed flags matter.
    for (int op = 0; op < 16; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [3:0] a_flags;
        logic [3:0] b_flags;
        logic [3:0] opv;
        logic       a_val;
        logic       b_val;
        logic       exp;
        opv     = 4'(op);
        a_val   = (ab >= 2);
        b_val   = (ab % 2) == 1;
        a_sel   = 2'($urandom);
        b_sel   = 2'($urandom);
        a_flags = 4'($urandom);
        b_flags = 4'($urandom);
        a_flags[a_sel] = a_val;
        b_flags[b_sel] = b_val;
        exp     = ((op >> ab) & 1) == 1;
        run($sformatf("sweep_op%0d_ab%0d", op, ab),
            a_sel, a_flags, b_sel, b_flags, opv, exp);
      end
    end

    // Mid-stream reset: predicate is 1 before, drops at once with no edge.
    run("pre_reset_fill1",    2'd0, 4'b0000, 2'd0, 4'b0000, 4'b1111, 1'b1);
    run("pre_reset_fill2",    2'd0, 4'b0000, 2'd0, 4'b0000, 4'b1111, 1'b1);
    run("pre_reset_is_1",     2'd0, 4'b0000, 2'd0, 4'b0000, 4'b1111, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("midreset_async", bus.predicate, 1'b0);
    @(posedge clock);
    #1 check("midreset_held", bus.predicate, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    sbq.delete();
    sbq.push_back(1'b0);
    // In-flight always-true results were discarded: first edge shows 0.
    run("post_mid_edge1",     2'd0, 4'b0000, 2'd0, 4'b0000, 4'b1111, 1'b1);
    run("post_mid_edge2",     2'd1, 4'b0010, 2'd0, 4'b0000, 4'b0011, 1'b0);
    run("post_mid_edge3",     2'd0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
